// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the integer ALU functional unit: opcode enum, FU type codes,
// datapath widths and the issue packet handed over by the reservation station.
package alu_exec_unit_pkg;

    localparam int XLEN      = 32;
    localparam int PREG_W    = 6;
    localparam int ROB_TAG_W = 5;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_LSU = 2'd1;
    localparam logic [1:0] FU_BRU = 2'd2;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic                 imm_used;
        alu_op_e              alu_op;
        logic [PREG_W-1:0]    rs1_tag;
        logic [PREG_W-1:0]    rs2_tag;
        logic [PREG_W-1:0]    rd_tag;
        logic                 rd_used;
        logic [ROB_TAG_W-1:0] rob_tag;
    } issue_pkt_t;

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Purely combinational integer ALU; shared with the branch unit, so it carries
// no pipeline state of its own.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  alu_op_e         alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = op_b[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = op_a + op_b;
            ALU_SUB:   result = op_a - op_b;
            ALU_AND:   result = op_a & op_b;
            ALU_OR:    result = op_a | op_b;
            ALU_XOR:   result = op_a ^ op_b;
            ALU_SLL:   result = op_a << shamt;
            ALU_SRL:   result = op_a >> shamt;
            ALU_SRA:   result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_LUI:   result = op_b;
            ALU_AUIPC: result = pc + imm;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage ALU unit (RR, EX): reads the PRF with same-cycle CDB bypass, executes,
// and holds the result on the CDB until the arbiter grants it.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 issue_valid_i,
    output logic                 exec_ready_o,
    input  issue_pkt_t           issue_pkt_i,
    output logic [PREG_W-1:0]    prf_rs1_tag_o,
    input  logic [XLEN-1:0]      prf_rs1_data_i,
    output logic [PREG_W-1:0]    prf_rs2_tag_o,
    input  logic [XLEN-1:0]      prf_rs2_data_i,
    output logic                 cdb_valid_o,
    input  logic                 cdb_ready_i,
    output logic [PREG_W-1:0]    cdb_tag_o,
    output logic [ROB_TAG_W-1:0] cdb_rob_tag_o,
    output logic                 cdb_rd_used_o,
    output logic [XLEN-1:0]      cdb_data_o,
    input  logic                 byp_valid_i,
    input  logic [PREG_W-1:0]    byp_tag_i,
    input  logic [XLEN-1:0]      byp_data_i
);

    // Handshake: an op moves into RR when issue_valid_i && exec_ready_o at a
    // rising edge; the result leaves EX when cdb_valid_o && cdb_ready_i.
    logic                 rr_valid;
    issue_pkt_t           rr_pkt;
    logic                 ex_valid;
    logic [XLEN-1:0]      ex_data;
    logic [PREG_W-1:0]    ex_tag;
    logic [ROB_TAG_W-1:0] ex_rob_tag;
    logic                 ex_rd_used;

    logic            ex_free;
    logic            rr_adv;
    logic            issue_fire;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;

    assign ex_free      = !ex_valid || cdb_ready_i;
    assign rr_adv       = rr_valid && ex_free;
    assign exec_ready_o = !rr_valid || rr_adv;
    assign issue_fire   = issue_valid_i && exec_ready_o;

    assign prf_rs1_tag_o = rr_pkt.rs1_tag;
    assign prf_rs2_tag_o = rr_pkt.rs2_tag;

    // Tag 0 is the zero register and must never pick up a bypass.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [PREG_W-1:0] tag,
        input logic [XLEN-1:0]   prf_data,
        input logic              byp_valid,
        input logic [PREG_W-1:0] byp_tag,
        input logic [XLEN-1:0]   byp_data
    );
        if (tag == '0)
            return '0;
        else if (byp_valid && byp_tag == tag)
            return byp_data;
        else
            return prf_data;
    endfunction

    assign rs1_val = pick_operand(rr_pkt.rs1_tag, prf_rs1_data_i, byp_valid_i, byp_tag_i, byp_data_i);
    assign rs2_val = pick_operand(rr_pkt.rs2_tag, prf_rs2_data_i, byp_valid_i, byp_tag_i, byp_data_i);
    assign op_b    = rr_pkt.imm_used ? rr_pkt.imm : rs2_val;

    alu_core u_alu_core (
        .alu_op (rr_pkt.alu_op),
        .op_a   (rs1_val),
        .op_b   (op_b),
        .pc     (rr_pkt.pc),
        .imm    (rr_pkt.imm),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_valid <= 1'b0;
            rr_pkt   <= '0;
        end else if (flush_i) begin
            rr_valid <= 1'b0;
        end else if (issue_fire) begin
            rr_valid <= 1'b1;
            rr_pkt   <= issue_pkt_i;
        end else if (rr_adv) begin
            rr_valid <= 1'b0;
        end
    end

    // EX registers only load on rr_adv, which cannot happen while a stalled
    // result is waiting, so the CDB payload stays stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_data    <= '0;
            ex_tag     <= '0;
            ex_rob_tag <= '0;
            ex_rd_used <= 1'b0;
        end else if (flush_i) begin
            ex_valid <= 1'b0;
        end else if (rr_adv) begin
            ex_valid   <= 1'b1;
            ex_data    <= alu_result;
            ex_tag     <= rr_pkt.rd_tag;
            ex_rob_tag <= rr_pkt.rob_tag;
            ex_rd_used <= rr_pkt.rd_used;
        end else if (cdb_ready_i) begin
            ex_valid <= 1'b0;
        end
    end

    assign cdb_valid_o   = ex_valid;
    assign cdb_data_o    = ex_data;
    assign cdb_tag_o     = ex_tag;
    assign cdb_rob_tag_o = ex_rob_tag;
    assign cdb_rd_used_o = ex_rd_used;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one task per scenario, inline checks,
// single summary line at the end.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 flush_i;
    logic                 issue_valid_i;
    logic                 exec_ready_o;
    issue_pkt_t           issue_pkt_i;
    logic [PREG_W-1:0]    prf_rs1_tag_o;
    logic [XLEN-1:0]      prf_rs1_data_i;
    logic [PREG_W-1:0]    prf_rs2_tag_o;
    logic [XLEN-1:0]      prf_rs2_data_i;
    logic                 cdb_valid_o;
    logic                 cdb_ready_i;
    logic [PREG_W-1:0]    cdb_tag_o;
    logic [ROB_TAG_W-1:0] cdb_rob_tag_o;
    logic                 cdb_rd_used_o;
    logic [XLEN-1:0]      cdb_data_o;
    logic                 byp_valid_i;
    logic [PREG_W-1:0]    byp_tag_i;
    logic [XLEN-1:0]      byp_data_i;

    logic [XLEN-1:0] prf [64];

    int checks   = 0;
    int failures = 0;

    alu_exec_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .exec_ready_o   (exec_ready_o),
        .issue_pkt_i    (issue_pkt_i),
        .prf_rs1_tag_o  (prf_rs1_tag_o),
        .prf_rs1_data_i (prf_rs1_data_i),
        .prf_rs2_tag_o  (prf_rs2_tag_o),
        .prf_rs2_data_i (prf_rs2_data_i),
        .cdb_valid_o    (cdb_valid_o),
        .cdb_ready_i    (cdb_ready_i),
        .cdb_tag_o      (cdb_tag_o),
        .cdb_rob_tag_o  (cdb_rob_tag_o),
        .cdb_rd_used_o  (cdb_rd_used_o),
        .cdb_data_o     (cdb_data_o),
        .byp_valid_i    (byp_valid_i),
        .byp_tag_i      (byp_tag_i),
        .byp_data_i     (byp_data_i)
    );

    // Combinational PRF model.
    assign prf_rs1_data_i = prf[prf_rs1_tag_o];
    assign prf_rs2_data_i = prf[prf_rs2_tag_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic issue_pkt_t mk_pkt(
        input logic [3:0]           op,
        input logic [PREG_W-1:0]    rs1,
        input logic [PREG_W-1:0]    rs2,
        input logic [XLEN-1:0]      imm,
        input logic                 imm_used,
        input logic [PREG_W-1:0]    rd,
        input logic [ROB_TAG_W-1:0] rob,
        input logic [XLEN-1:0]      pc
    );
        issue_pkt_t p;
        p.pc       = pc;
        p.imm      = imm;
        p.imm_used = imm_used;
        p.alu_op   = alu_op_e'(op);
        p.rs1_tag  = rs1;
        p.rs2_tag  = rs2;
        p.rd_tag   = rd;
        p.rd_used  = 1'b1;
        p.rob_tag  = rob;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; returns #1 after the accepting edge.
    task automatic issue_op(input issue_pkt_t p);
        issue_valid_i = 1'b1;
        issue_pkt_i   = p;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_pkt_i = '0;
        cdb_ready_i = 1'b1; byp_valid_i = 1'b0; byp_tag_i = '0; byp_data_i = '0;
        for (int i = 0; i < 64; i++) prf[i] = '0;
        tick(); tick();
        checks++;
        if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_cdb_valid got=%0b exp=0", cdb_valid_o); end
        checks++;
        if (cdb_data_o !== '0 || cdb_tag_o !== '0 || cdb_rob_tag_o !== '0 || cdb_rd_used_o !== 1'b0) begin
            failures++; $display("FAIL reset_payload data=%h tag=%0d rob=%0d used=%0b exp all 0", cdb_data_o, cdb_tag_o, cdb_rob_tag_o, cdb_rd_used_o);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (exec_ready_o !== 1'b1) begin failures++; $display("FAIL reset_exec_ready got=%0b exp=1", exec_ready_o); end
    endtask

    task automatic test_add();
        prf[3] = 32'd5; prf[4] = 32'd7;
        issue_op(mk_pkt(4'd0, 6'd3, 6'd4, 32'd0, 1'b0, 6'd9, 5'd5, 32'd0));
        checks++;
        if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%0b exp=0", cdb_valid_o); end
        tick();
        checks++;
        if (cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd12 || cdb_tag_o !== 6'd9 || cdb_rob_tag_o !== 5'd5 || cdb_rd_used_o !== 1'b1) begin
            failures++; $display("FAIL add_result valid=%0b data=%0d tag=%0d rob=%0d exp valid=1 data=12 tag=9 rob=5", cdb_valid_o, cdb_data_o, cdb_tag_o, cdb_rob_tag_o);
        end
        tick();
        checks++;
        if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL add_drain got=%0b exp=0", cdb_valid_o); end
    endtask

    task automatic test_ops();
        issue_pkt_t      pkts [12];
        logic [XLEN-1:0] exp  [12];
        prf[10] = 32'h8000_0000; prf[11] = 32'd4; prf[12] = 32'hFFFF_FFFF; prf[13] = 32'd1;
        pkts[0]  = mk_pkt(4'd1,  6'd0,  6'd0,  32'd1,          1'b1, 6'd1, 5'd1, 32'd0); exp[0]  = 32'hFFFF_FFFF;
        pkts[1]  = mk_pkt(4'd7,  6'd10, 6'd11, 32'd0,          1'b0, 6'd2, 5'd2, 32'd0); exp[1]  = 32'hF800_0000;
        pkts[2]  = mk_pkt(4'd6,  6'd10, 6'd11, 32'd0,          1'b0, 6'd3, 5'd3, 32'd0); exp[2]  = 32'h0800_0000;
        pkts[3]  = mk_pkt(4'd5,  6'd13, 6'd0,  32'd31,         1'b1, 6'd4, 5'd4, 32'd0); exp[3]  = 32'h8000_0000;
        pkts[4]  = mk_pkt(4'd8,  6'd12, 6'd0,  32'd1,          1'b1, 6'd5, 5'd5, 32'd0); exp[4]  = 32'd1;
        pkts[5]  = mk_pkt(4'd9,  6'd12, 6'd0,  32'd1,          1'b1, 6'd6, 5'd6, 32'd0); exp[5]  = 32'd0;
        pkts[6]  = mk_pkt(4'd2,  6'd3,  6'd4,  32'd0,          1'b0, 6'd7, 5'd7, 32'd0); exp[6]  = 32'd5;
        pkts[7]  = mk_pkt(4'd3,  6'd3,  6'd4,  32'd0,          1'b0, 6'd8, 5'd8, 32'd0); exp[7]  = 32'd7;
        pkts[8]  = mk_pkt(4'd4,  6'd3,  6'd0,  32'd3,          1'b1, 6'd9, 5'd9, 32'd0); exp[8]  = 32'd6;
        pkts[9]  = mk_pkt(4'd10, 6'd3,  6'd0,  32'h1234_5000,  1'b1, 6'd10, 5'd10, 32'd0); exp[9]  = 32'h1234_5000;
        pkts[10] = mk_pkt(4'd11, 6'd3,  6'd0,  32'h20,         1'b1, 6'd11, 5'd11, 32'h1000); exp[10] = 32'h1020;
        pkts[11] = mk_pkt(4'd13, 6'd12, 6'd12, 32'd0,          1'b0, 6'd12, 5'd12, 32'd0); exp[11] = 32'd0;
        for (int i = 0; i < 12; i++) begin
            issue_op(pkts[i]);
            tick();
            checks++;
            if (cdb_valid_o !== 1'b1 || cdb_data_o !== exp[i] || cdb_rob_tag_o !== pkts[i].rob_tag) begin
                failures++; $display("FAIL op_%0d valid=%0b data=%h rob=%0d exp data=%h rob=%0d", i, cdb_valid_o, cdb_data_o, cdb_rob_tag_o, exp[i], pkts[i].rob_tag);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_q [$];
        logic [XLEN-1:0] e;
        cdb_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                issue_valid_i = 1'b1;
                issue_pkt_i   = mk_pkt(4'd0, 6'd3, 6'd0, 32'(c + 1), 1'b1, 6'(20 + c), 5'(c + 1), 32'd0);
                exp_q.push_back(32'(6 + c));
                checks++;
                if (exec_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%0b exp=1", c, exec_ready_o); end
            end else begin
                issue_valid_i = 1'b0;
            end
            tick();
            if (c >= 1) begin
                e = exp_q.pop_front();
                checks++;
                if (cdb_valid_o !== 1'b1 || cdb_data_o !== e || cdb_rob_tag_o !== 5'(c)) begin
                    failures++; $display("FAIL b2b_result_%0d valid=%0b data=%0d rob=%0d exp data=%0d rob=%0d", c - 1, cdb_valid_o, cdb_data_o, cdb_rob_tag_o, e, c);
                end
            end
        end
        issue_valid_i = 1'b0;
        tick();
        checks++;
        if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", cdb_valid_o); end
    endtask

    task automatic test_stall();
        cdb_ready_i = 1'b0;
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd10, 1'b1, 6'd30, 5'd6, 32'd0));
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd20, 1'b1, 6'd31, 5'd7, 32'd0));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (exec_ready_o !== 1'b0 || cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd15 || cdb_tag_o !== 6'd30 || cdb_rob_tag_o !== 5'd6) begin
                failures++; $display("FAIL stall_hold_%0d ready=%0b valid=%0b data=%0d tag=%0d rob=%0d exp ready=0 valid=1 data=15 tag=30 rob=6", k, exec_ready_o, cdb_valid_o, cdb_data_o, cdb_tag_o, cdb_rob_tag_o);
            end
            tick();
        end
        cdb_ready_i = 1'b1;
        tick();
        checks++;
        if (cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd25 || cdb_rob_tag_o !== 5'd7) begin
            failures++; $display("FAIL stall_release valid=%0b data=%0d rob=%0d exp valid=1 data=25 rob=7", cdb_valid_o, cdb_data_o, cdb_rob_tag_o);
        end
        tick();
        checks++;
        if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL stall_no_dup got=%0b exp=0", cdb_valid_o); end
    endtask

    task automatic test_bypass();
        prf[20] = 32'd0; prf[21] = 32'd0; prf[3] = 32'd5;
        issue_op(mk_pkt(4'd0, 6'd20, 6'd0, 32'd0, 1'b1, 6'd40, 5'd8, 32'd0));
        byp_valid_i = 1'b1; byp_tag_i = 6'd20; byp_data_i = 32'd100;
        checks++;
        if (prf_rs1_tag_o !== 6'd20) begin failures++; $display("FAIL byp_prf_tag got=%0d exp=20", prf_rs1_tag_o); end
        tick();
        byp_valid_i = 1'b0;
        checks++;
        if (cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd100) begin failures++; $display("FAIL byp_rs1 valid=%0b data=%0d exp data=100", cdb_valid_o, cdb_data_o); end
        issue_op(mk_pkt(4'd0, 6'd3, 6'd21, 32'd0, 1'b0, 6'd41, 5'd9, 32'd0));
        byp_valid_i = 1'b1; byp_tag_i = 6'd21; byp_data_i = 32'd200;
        tick();
        byp_valid_i = 1'b0;
        checks++;
        if (cdb_data_o !== 32'd205) begin failures++; $display("FAIL byp_rs2 data=%0d exp=205", cdb_data_o); end
        issue_op(mk_pkt(4'd0, 6'd0, 6'd0, 32'd0, 1'b1, 6'd42, 5'd10, 32'd0));
        byp_valid_i = 1'b1; byp_tag_i = 6'd0; byp_data_i = 32'd55;
        tick();
        byp_valid_i = 1'b0;
        checks++;
        if (cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd0) begin failures++; $display("FAIL byp_tag0 valid=%0b data=%0d exp data=0", cdb_valid_o, cdb_data_o); end
        tick();
    endtask

    task automatic test_flush();
        cdb_ready_i = 1'b0;
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd1, 1'b1, 6'd50, 5'd11, 32'd0));
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd2, 1'b1, 6'd51, 5'd12, 32'd0));
        flush_i       = 1'b1;
        issue_valid_i = 1'b1;
        issue_pkt_i   = mk_pkt(4'd0, 6'd3, 6'd0, 32'd3, 1'b1, 6'd52, 5'd13, 32'd0);
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0; cdb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cdb_valid_o !== 1'b0 || exec_ready_o !== 1'b1) begin
                failures++; $display("FAIL flush_idle_%0d valid=%0b ready=%0b exp valid=0 ready=1", k, cdb_valid_o, exec_ready_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        cdb_ready_i = 1'b0;
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd4, 1'b1, 6'd53, 5'd14, 32'd0));
        issue_op(mk_pkt(4'd0, 6'd3, 6'd0, 32'd5, 1'b1, 6'd54, 5'd15, 32'd0));
        checks++;
        if (cdb_valid_o !== 1'b1 || cdb_data_o !== 32'd9) begin failures++; $display("FAIL rstmid_pre valid=%0b data=%0d exp valid=1 data=9", cdb_valid_o, cdb_data_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cdb_valid_o !== 1'b0 || exec_ready_o !== 1'b1 || cdb_data_o !== '0 || cdb_tag_o !== '0) begin
            failures++; $display("FAIL rstmid_async valid=%0b ready=%0b data=%0d tag=%0d exp 0/1/0/0", cdb_valid_o, exec_ready_o, cdb_data_o, cdb_tag_o);
        end
        tick();
        rst_n = 1'b1; cdb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (cdb_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_after_%0d valid=%0b exp=0", k, cdb_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_back_to_back();
        test_stall();
        test_bypass();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
